// File: rtl/dmem_if.sv
// dmem_if: requester handshakes and DataMemory bus around dmem_arbiter.
// master = requesters/memory side, slave = arbiter side.
interface dmem_if;
  logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    input  m0_gnt, m0_done, m0_rdata, m0_err, m1_gnt, m1_done, m1_rdata, m1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    output m0_gnt, m0_done, m0_rdata, m0_err, m1_gnt, m1_done, m1_rdata, m1_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the 16-bit DataMemory between CPU (port 0) and DMA (port 1).
// Define DMEM_ADDR_CHECK_EN to flag addresses >= MEM_DEPTH and suppress their strobes.
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_DEPTH   = 1024
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus,
  output logic  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
  stateT state, stateNxt;
  logic lastOwner, lastOwnerNxt, owner, ownerNxt, latWe, latWeNxt, latErr, latErrNxt;
  logic sel, selErr, finish;
  logic [3:0] waitCnt, waitCntNxt;
  logic [1:0] gnt, gntNxt, done, doneNxt;
  logic [1:0][15:0] rdata, rdataNxt;
  logic memRead, memReadNxt, memWrite, memWriteNxt;
  logic [15:0] memAddr, memAddrNxt, memWdata, memWdataNxt, selAddr;

  // Tie goes to the port that was not served last
  assign sel     = (bus.m0_req && bus.m1_req) ? !lastOwner : bus.m1_req;
  assign selAddr = sel ? bus.m1_addr : bus.m0_addr;
  assign finish  = (state == ACCESS) && (waitCnt == 4'd0);

`ifdef DMEM_ADDR_CHECK_EN
  logic [1:0] err;
  assign selErr = {16'd0, selAddr} >= 32'(MEM_DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 2'b00;
    else err <= (finish && latErr) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m0_err = err[0];
  assign bus.m1_err = err[1];
`else
  // No range check in this build; err stays 0
  assign selErr     = MEM_DEPTH[0] & 1'b0;
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

  always_comb begin
    stateNxt     = state;
    ownerNxt     = owner;
    latWeNxt     = latWe;
    latErrNxt    = latErr;
    lastOwnerNxt = lastOwner;
    waitCntNxt   = waitCnt;
    gntNxt       = 2'b00;
    doneNxt      = 2'b00;
    rdataNxt     = rdata;
    memReadNxt   = memRead;
    memWriteNxt  = memWrite;
    memAddrNxt   = memAddr;
    memWdataNxt  = memWdata;
    if (state == IDLE && (bus.m0_req || bus.m1_req)) begin
      stateNxt     = ACCESS;
      ownerNxt     = sel;
      latWeNxt     = sel ? bus.m1_we : bus.m0_we;
      latErrNxt    = selErr;
      waitCntNxt   = 4'(WAIT_CYCLES);
      gntNxt[sel]  = 1'b1;
      memAddrNxt   = selAddr;
      memWdataNxt  = sel ? bus.m1_wdata : bus.m0_wdata;
      memReadNxt   = !latWeNxt && !selErr;
      memWriteNxt  = latWeNxt && !selErr;
    end else if (finish) begin
      stateNxt       = DONE;
      lastOwnerNxt   = owner;
      doneNxt[owner] = 1'b1;
      memReadNxt     = 1'b0;
      memWriteNxt    = 1'b0;
      if (latErr || !latWe) rdataNxt[owner] = latErr ? 16'h0000 : bus.mem_rdata;
    end else if (state == ACCESS) begin
      waitCntNxt = waitCnt - 4'd1;
    end else if (state == DONE) begin
      stateNxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      latWe     <= 1'b0;
      latErr    <= 1'b0;
      lastOwner <= 1'b1;
      waitCnt   <= 4'd0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      rdata     <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= 16'h0000;
      memWdata  <= 16'h0000;
    end else begin
      state     <= stateNxt;
      owner     <= ownerNxt;
      latWe     <= latWeNxt;
      latErr    <= latErrNxt;
      lastOwner <= lastOwnerNxt;
      waitCnt   <= waitCntNxt;
      gnt       <= gntNxt;
      done      <= doneNxt;
      rdata     <= rdataNxt;
      memRead   <= memReadNxt;
      memWrite  <= memWriteNxt;
      memAddr   <= memAddrNxt;
      memWdata  <= memWdataNxt;
    end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_done   = done[0];
  assign bus.m1_done   = done[1];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];
  assign bus.mem_read  = memRead;
  assign bus.mem_write = memWrite;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign busy          = state != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter (WAIT_CYCLES=1) against a behavioural DataMemory.
// Bounds-check steps are included when DMEM_ADDR_CHECK_EN is defined.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int tests = 0;
  int fails = 0;
  int wrCount = 0;
  logic [15:0] mem [0:1023];
  logic [15:0] rd, r0;
  logic er;
  int lat, t0, t1;

  dmem_if bus();
  dmem_arbiter #(.WAIT_CYCLES(1), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy)
  );

  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    if (bus.mem_write) wrCount <= wrCount + 1;
  end

  // Strobes exclusive, at most one grant and one done at a time
  always @(negedge clk) if (rst_n) begin
    tests++;
    assert (!(bus.mem_read && bus.mem_write) && !(bus.m0_gnt && bus.m1_gnt) && !(bus.m0_done && bus.m1_done))
      else begin
        fails++;
        $error("FAIL excl: rd/wr=%b%b gnt=%b%b done=%b%b required no overlap", bus.mem_read, bus.mem_write,
               bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done);
      end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on port p; returns captured rdata/err and negedges from request to done, then idles one cycle
  task automatic access(input logic p, input logic we, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rdo, output logic ero, output int l);
    if (p) begin bus.m1_req = 1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; end
    else begin bus.m0_req = 1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; end
    l = -1; rdo = 'x; ero = 'x;
    for (int i = 1; i <= 20 && l < 0; i++) begin
      @(negedge clk);
      if (p ? bus.m1_gnt : bus.m0_gnt) begin if (p) bus.m1_req = 0; else bus.m0_req = 0; end
      if (p ? bus.m1_done : bus.m0_done) begin
        l = i; rdo = p ? bus.m1_rdata : bus.m0_rdata; ero = p ? bus.m1_err : bus.m0_err;
      end
    end
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);
  endtask

  initial begin
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    #22;
    chk("rst_ctl", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
                    bus.mem_read, bus.mem_write, busy}, 0);
    chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
    #(5 + $urandom_range(0, 4)) rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      chk("idle", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
                   bus.mem_read, bus.mem_write, busy}, 0);
    end
    // m0 writes 0x02AF to address 20
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'd20; bus.m0_wdata = 16'h02AF;
    @(negedge clk);
    chk("wr_gnt", {bus.m0_gnt, bus.m1_gnt, bus.mem_write, bus.mem_read, busy}, 5'b10101);
    chk("wr_bus", {bus.mem_addr, bus.mem_wdata}, {16'd20, 16'h02AF});
    bus.m0_req = 0;
    @(negedge clk);
    chk("wr_hold", {bus.m0_gnt, bus.mem_write, bus.m0_done, bus.mem_addr}, {3'b010, 16'd20});
    @(negedge clk);
    chk("wr_done", {bus.m0_done, bus.mem_write, busy}, 3'b101);
    chk("wr_mem", mem[20], 16'h02AF);
    @(negedge clk);
    chk("wr_idle", {bus.m0_done, busy}, 0);
    access(0, 0, 16'd20, 16'h0, rd, er, lat);
    chk("rd_data", rd, 16'h02AF);
    chk("rd_err", er, 0);
    chk("rd_lat", 32'(lat), 3);
    // Simultaneous reads after reset, both held: grants m0, m1, m0 every 4 cycles
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    bus.m0_we = 0; bus.m0_addr = 16'd20; bus.m1_we = 0; bus.m1_addr = 16'd20;
    bus.m0_req = 1; bus.m1_req = 1;
    @(negedge clk);
    chk("tie1", {bus.m0_gnt, bus.m1_gnt}, 2'b10);
    repeat (2) @(negedge clk);
    chk("tie1_done", {bus.m0_done, bus.m1_done, bus.m0_rdata}, {2'b10, 16'h02AF});
    @(negedge clk);
    chk("tie_idle", {bus.m0_gnt, bus.m1_gnt, busy}, 0);
    @(negedge clk);
    chk("tie2", {bus.m0_gnt, bus.m1_gnt}, 2'b01);
    repeat (2) @(negedge clk);
    chk("tie2_done", {bus.m0_done, bus.m1_done, bus.m1_rdata}, {2'b01, 16'h02AF});
    repeat (2) @(negedge clk);
    chk("tie3", {bus.m0_gnt, bus.m1_gnt}, 2'b10);
    bus.m0_req = 0; bus.m1_req = 0;
    repeat (3) @(negedge clk);
    // Port isolation: m1 (next in turn) writes addr 5, m0 reads it
    bus.m1_we = 1; bus.m1_addr = 16'd5; bus.m1_wdata = 16'h1234;
    bus.m0_we = 0; bus.m0_addr = 16'd5;
    bus.m0_req = 1; bus.m1_req = 1;
    t0 = -1; t1 = -1; r0 = 'x;
    for (int i = 0; i < 20 && (t0 < 0 || t1 < 0); i++) begin
      @(negedge clk);
      if (bus.m0_gnt) bus.m0_req = 0;
      if (bus.m1_gnt) bus.m1_req = 0;
      if (bus.m0_done) begin t0 = i; r0 = bus.m0_rdata; end
      if (bus.m1_done) t1 = i;
    end
    bus.m0_req = 0; bus.m1_req = 0;
    chk("iso_order", {31'd0, t1 >= 0 && t0 > t1}, 1);
    chk("iso_m0", r0, 16'h1234);
    chk("iso_m1", bus.m1_rdata, 16'h02AF);
    @(negedge clk);
    // Reset during the first ACCESS cycle of an m0 read
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 16'd5;
    @(negedge clk);
    chk("mr_gnt", {bus.m0_gnt, bus.mem_read}, 2'b11);
    bus.m0_req = 0;
    #2 rst_n = 0;
    #1;
    chk("mr_drop", {bus.mem_read, bus.mem_write, busy, bus.m0_gnt}, 0);
    chk("mr_rdata", bus.m0_rdata, 0);
    #3 rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("mr_nodone", {bus.m0_done, bus.m1_done, busy}, 0);
    end
    access(0, 0, 16'd5, 16'h0, rd, er, lat);
    chk("mr_next", rd, 16'h1234);
    chk("mr_lat", 32'(lat), 3);
`ifdef DMEM_ADDR_CHECK_EN
    access(1, 0, 16'd5, 16'h0, rd, er, lat);
    chk("oob_pre", {er, rd}, {1'b0, 16'h1234});
    r0 = mem[0];
    t0 = wrCount;
    access(1, 1, 16'd1024, 16'hBEEF, rd, er, lat);
    chk("oob_err", {er, rd}, {1'b1, 16'h0000});
    chk("oob_lat", 32'(lat), 3);
    chk("oob_nowr", 32'(wrCount - t0), 0);
    chk("oob_mem0", mem[0], r0);
    chk("oob_m1rd", bus.m1_rdata, 16'h0000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end
endmodule
